// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider: one valid/ready channel in, one out.
// The divider takes the slave view; the producer/consumer side takes the master view.
interface seq_divider_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] N;
  logic [WIDTH-1:0] D;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             div_by_zero;

  modport master (
    output in_valid, N, D, signed_mode, out_ready,
    input  in_ready, out_valid, Q, R, div_by_zero
  );

  modport slave (
    input  in_valid, N, D, signed_mode, out_ready,
    output in_ready, out_valid, Q, R, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock, unsigned or signed
// (truncate toward zero) operands, with divide-by-zero flagging.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  // Operand/iteration registers
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_signed;
  logic             r_neg_n;
  logic             r_neg_d;
  logic             r_zero;
  logic             r_final;

  // Result registers
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;

  logic             w_accept;
  logic             w_d_zero;
  logic [WIDTH-1:0] w_abs_n;
  logic [WIDTH-1:0] w_abs_d;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: state and datapath registers use non-blocking (<=) so every flop
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_accept      = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept     = 1'b1;
          w_next_state = CALC;
        end
      end
      CALC: begin
        if (r_final) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand conditioning
  // ---------------------------------------------------------------------------
  assign w_d_zero = (bus.D == '0);
  assign w_abs_n  = (bus.signed_mode && bus.N[WIDTH-1]) ? -bus.N : bus.N;
  assign w_abs_d  = (bus.signed_mode && bus.D[WIDTH-1]) ? -bus.D : bus.D;

  // ---------------------------------------------------------------------------
  // Restoring iteration. The shifted partial remainder carries one extra bit
  // so the compare against a full-width divisor cannot overflow. The stored
  // remainder is always below the divisor, so WIDTH bits hold it, and the low
  // WIDTH bits of the subtraction are exact whenever w_ge is set.
  // ---------------------------------------------------------------------------
  assign w_shift = {r_rem, r_dividend[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_divisor});
  assign w_diff  = w_shift[WIDTH-1:0] - r_divisor;

  // Quotient sign follows the operand signs; the remainder follows the dividend.
  assign w_q_fix = (r_signed && (r_neg_n ^ r_neg_d)) ? -r_quot : r_quot;
  assign w_r_fix = (r_signed && r_neg_n) ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_signed   <= 1'b0;
      r_neg_n    <= 1'b0;
      r_neg_d    <= 1'b0;
      r_zero     <= 1'b0;
      r_final    <= 1'b0;
      r_q        <= '0;
      r_r        <= '0;
      r_dbz      <= 1'b0;
    end else if (w_accept) begin
      r_signed   <= bus.signed_mode;
      r_neg_n    <= bus.N[WIDTH-1];
      r_neg_d    <= bus.D[WIDTH-1];
      r_zero     <= w_d_zero;
      // A zero divisor skips the iterations and must report the raw dividend.
      r_dividend <= w_d_zero ? bus.N : w_abs_n;
      r_divisor  <= w_abs_d;
      r_quot     <= '0;
      r_rem      <= '0;
      r_cnt      <= CNT_W'(WIDTH - 1);
      r_final    <= w_d_zero;
    end else if (r_state == CALC) begin
      if (r_final) begin
        r_final <= 1'b0;
        if (r_zero) begin
          r_q   <= '1;
          r_r   <= r_dividend;
          r_dbz <= 1'b1;
        end else begin
          r_q   <= w_q_fix;
          r_r   <= w_r_fix;
          r_dbz <= 1'b0;
        end
      end else begin
        r_rem      <= w_ge ? w_diff : w_shift[WIDTH-1:0];
        r_quot     <= {r_quot[WIDTH-2:0], w_ge};
        r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
        r_cnt      <= r_cnt - CNT_W'(1);
        if (r_cnt == '0) begin
          r_final <= 1'b1;
        end
      end
    end
  end

  assign bus.Q           = r_q;
  assign bus.R           = r_r;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: a 16-bit and an 8-bit instance, expected
// results from an arithmetic reference model, compared on each output handshake.
module tb_seq_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb16[$];
  exp_t sb8[$];
  exp_t e16;
  exp_t e8;

  logic [1:0]  tb_vld;
  logic [31:0] tb_n;
  logic [31:0] tb_d;
  logic        tb_sm;
  logic        tb_out_ready;
  bit          sel;

  seq_divider_if #(.WIDTH(16)) b16 ();
  seq_divider_if #(.WIDTH(8))  b8 ();

  assign b16.in_valid    = tb_vld[0];
  assign b16.N           = tb_n[15:0];
  assign b16.D           = tb_d[15:0];
  assign b16.signed_mode = tb_sm;
  assign b16.out_ready   = tb_out_ready;
  assign b8.in_valid     = tb_vld[1];
  assign b8.N            = tb_n[7:0];
  assign b8.D            = tb_d[7:0];
  assign b8.signed_mode  = tb_sm;
  assign b8.out_ready    = tb_out_ready;

  seq_divider #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  seq_divider #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic cur_ready();
    return sel ? b8.in_ready : b16.in_ready;
  endfunction
  function automatic logic cur_valid();
    return sel ? b8.out_valid : b16.out_valid;
  endfunction
  function automatic logic [31:0] cur_q();
    return sel ? {24'd0, b8.Q} : {16'd0, b16.Q};
  endfunction
  function automatic logic [31:0] cur_r();
    return sel ? {24'd0, b8.R} : {16'd0, b16.R};
  endfunction
  function automatic logic cur_dbz();
    return sel ? b8.div_by_zero : b16.div_by_zero;
  endfunction

  // Reference: native 64-bit division, which truncates toward zero and gives
  // the remainder the dividend's sign.
  function automatic exp_t model(input int w, input logic [31:0] n, input logic [31:0] d,
                                 input logic sm);
    exp_t   e;
    longint a, b, q, r;
    longint mask;
    mask  = (longint'(1) << w) - 1;
    e.dbz = 1'b0;
    if (d == 0) begin
      e.q   = 32'(mask);
      e.r   = n;
      e.dbz = 1'b1;
      return e;
    end
    a = longint'(n);
    b = longint'(d);
    if (sm) begin
      if (n[w-1]) a = a - (longint'(1) << w);
      if (d[w-1]) b = b - (longint'(1) << w);
    end
    q   = a / b;
    r   = a % b;
    e.q = 32'(q & mask);
    e.r = 32'(r & mask);
    return e;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, cur_ready(), 1);
    check({tag, "_out_valid"}, cur_valid(), 0);
    check({tag, "_q"}, cur_q(), 0);
    check({tag, "_r"}, cur_r(), 0);
    check({tag, "_dbz"}, cur_dbz(), 0);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
  task automatic send(input bit s, input logic [31:0] n, input logic [31:0] d, input logic sm);
    int waited;
    waited = 0;
    sel    = s;
    while (!cur_ready() && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("accept_ready", cur_ready(), 1);
    tb_n  = n;
    tb_d  = d;
    tb_sm = sm;
    if (s) begin
      sb8.push_back(model(8, n, d, sm));
      tb_vld = 2'b10;
    end else begin
      sb16.push_back(model(16, n, d, sm));
      tb_vld = 2'b01;
    end
    @(posedge clk);
    #1;
    tb_vld = 2'b00;
    tb_n   = $urandom;
    tb_d   = $urandom;
    tb_sm  = ~sm;
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int lat;
    bit rdy_seen;
    lat      = 0;
    rdy_seen = 1'b0;
    while (!cur_valid() && lat < 100) begin
      rdy_seen |= cur_ready();
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy"}, rdy_seen, 0);
  endtask

  task automatic run(input string tag, input bit s, input logic [31:0] n, input logic [31:0] d,
                     input logic sm);
    logic [31:0] mask;
    int          w;
    w    = s ? 8 : 16;
    mask = s ? 32'h0000_00FF : 32'h0000_FFFF;
    send(s, n & mask, d & mask, sm);
    wait_result(tag, ((d & mask) == 0) ? 1 : w + 1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && b16.out_valid && b16.out_ready) begin
      check("sb16_depth", sb16.size(), 1);
      if (sb16.size() > 0) begin
        e16 = sb16.pop_front();
        check("q16", {16'd0, b16.Q}, e16.q);
        check("r16", {16'd0, b16.R}, e16.r);
        check("dbz16", b16.div_by_zero, e16.dbz);
      end
    end
    if (rst_n && b8.out_valid && b8.out_ready) begin
      check("sb8_depth", sb8.size(), 1);
      if (sb8.size() > 0) begin
        e8 = sb8.pop_front();
        check("q8", {24'd0, b8.Q}, e8.q);
        check("r8", {24'd0, b8.R}, e8.r);
        check("dbz8", b8.div_by_zero, e8.dbz);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] n, d;
    logic        sm;
    bit          s;

    tb_vld       = 2'b00;
    tb_n         = '0;
    tb_d         = '0;
    tb_sm        = 1'b0;
    tb_out_ready = 1'b1;
    sel          = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_reset("rst16");
    sel = 1'b1;
    check_reset("rst8");
    sel   = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned and signed basics, divide-by-zero, signed overflow
    run("u1000_7", 0, 1000, 7, 0);
    run("s_m7_2", 0, 32'hFFF9, 2, 1);
    run("s_7_m2", 0, 7, 32'hFFFE, 1);
    run("u_dbz", 0, 1234, 0, 0);
    run("s_dbz", 0, 1234, 0, 1);
    run("s_ovf", 0, 32'h8000, 32'hFFFF, 1);

    // Backpressure: result held, in_valid ignored while DONE
    tb_out_ready = 1'b0;
    send(0, 500, 3, 0);
    wait_result("bp", 17);
    for (int i = 0; i < 5; i++) begin
      tb_vld = 2'b01;
      tb_n   = 9;
      tb_d   = 9;
      check("bp_q", cur_q(), 166);
      check("bp_r", cur_r(), 2);
      check("bp_in_ready", cur_ready(), 0);
      check("bp_out_valid", cur_valid(), 1);
      @(posedge clk);
      #1;
    end
    tb_vld       = 2'b00;
    tb_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ready_after", cur_ready(), 1);
    check("bp_valid_after", cur_valid(), 0);
    check("bp_q_hold", cur_q(), 166);
    check("bp_r_hold", cur_r(), 2);
    run("bp_next", 0, 100, 10, 0);

    // Abort mid-calculation with reset
    send(0, 60000, 9, 0);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset("abort");
    sb16.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("u60000_9", 0, 60000, 9, 0);

    // 8-bit instance
    run("w8_255_16", 1, 255, 16, 0);
    run("w8_s_m128_m1", 1, 32'h80, 32'hFF, 1);

    // Random sweep over both widths and modes with corner divisors/dividends
    for (int k = 0; k < 60; k++) begin
      s  = k[0];
      sm = 1'($urandom_range(0, 1));
      n  = $urandom;
      unique case (k % 6)
        0: d = 1;
        1: begin
          n = 0;
          d = $urandom_range(1, 200);
        end
        2: begin
          d = $urandom_range(20, 120);
          n = $urandom_range(0, 19);
        end
        3: d = 0;
        4: d = $urandom_range(1, 255);
        default: d = $urandom;
      endcase
      run("sweep", s, n, d, sm);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb16_left", sb16.size(), 0);
    check("sb8_left", sb8.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
